stage_sequencer: RTL and testbench

- Upstream driver of the control decoder. Generates the 2-bit machine-cycle code `stage` (LOAD=00, FETCH=01, DECODE=10, EXECUTE=11) that the decoder consumes.
- Runs the program-load handshake that fills program memory while in LOAD.
- Provides run/halt/single-step control at instruction boundaries.
- Provides `stage_valid`. The datapath ANDs every register enable with it, so a halted core is frozen.

---
 rtl/stage_sequencer.sv | 117 +++++++++++
 tb/tb_stage_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// Machine-cycle sequencer: program load, fetch/decode/execute
// stepping, and run/halt/single-step control at instruction boundaries.
module stage_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int PMEM_DEPTH = 256,
  parameter int INSTR_W    = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  output logic               load_ready,
  output logic               pmem_load_we,
  output logic [ADDR_W-1:0]  pmem_load_addr,
  output logic [INSTR_W-1:0] pmem_load_data,
  input  logic               run_en,
  input  logic               step_req,
  input  logic               halt_req,
  input  logic               reload_req,
  output logic [1:0]         stage,
  output logic               stage_valid,
  output logic               pc_clr,
  output logic               load_full,
  output logic [15:0]        instr_count
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST =
    ADDR_W'(PMEM_DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              step_q;
  logic              accept;
  logic              go;
  logic              at_end;

  assign load_ready     = (state == S_LOAD);
  assign accept         = load_valid & load_ready;
  assign pmem_load_we   = accept;
  assign pmem_load_addr = addr;
  assign pmem_load_data = load_data;
  assign stage_valid    = (state != S_HALT);
  assign go             = run_en & ~halt_req;
  assign at_end         = (addr == ADDR_LAST);

  always_comb begin
    stage = 2'b11;
    case (state)
      S_LOAD:   stage = 2'b00;
      S_FETCH:  stage = 2'b01;
      S_DECODE: stage = 2'b10;
      default:  stage = 2'b11;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_LOAD;
      addr        <= '0;
      pc_clr      <= 1'b0;
      load_full   <= 1'b0;
      instr_count <= '0;
      step_q      <= 1'b0;
    end else begin
      pc_clr <= 1'b0;
      case (state)
        S_LOAD: begin
          if (accept) begin
            if (load_last || at_end) begin
              addr   <= '0;
              pc_clr <= 1'b1;
              state  <= go ? S_FETCH : S_HALT;
              if (!load_last) load_full <= 1'b1;
            end else begin
              addr <= addr + 1'b1;
            end
          end
        end
        S_FETCH:  state <= S_DECODE;
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          instr_count <= instr_count + 16'd1;
          if (halt_req || !run_en || step_q) begin
            state  <= S_HALT;
            step_q <= 1'b0;
          end else begin
            state <= S_FETCH;
          end
        end
        S_HALT: begin
          // reload beats step beats free-run
          if (reload_req) begin
            state     <= S_LOAD;
            addr      <= '0;
            load_full <= 1'b0;
          end else if (step_req) begin
            state  <= S_FETCH;
            step_q <= 1'b1;
          end else if (go) begin
            state <= S_FETCH;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: phase-counter reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_stage_sequencer;

  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int IW    = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic [IW-1:0] load_data = '0;
  logic          load_last = 1'b0;
  logic          load_ready;
  logic          pmem_load_we;
  logic [AW-1:0] pmem_load_addr;
  logic [IW-1:0] pmem_load_data;
  logic          run_en = 1'b0;
  logic          step_req = 1'b0;
  logic          halt_req = 1'b0;
  logic          reload_req = 1'b0;
  logic [1:0]    stage;
  logic          stage_valid;
  logic          pc_clr;
  logic          load_full;
  logic [15:0]   instr_count;

  stage_sequencer #(
    .ADDR_W(AW), .PMEM_DEPTH(DEPTH), .INSTR_W(IW)
  ) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready),
    .pmem_load_we(pmem_load_we),
    .pmem_load_addr(pmem_load_addr),
    .pmem_load_data(pmem_load_data),
    .run_en(run_en), .step_req(step_req),
    .halt_req(halt_req), .reload_req(reload_req),
    .stage(stage), .stage_valid(stage_valid),
    .pc_clr(pc_clr), .load_full(load_full),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // reference model: mode flags plus position within an instruction
  bit m_loading, m_halted, m_step, m_pcclr, m_full;
  int m_phase, m_addr, m_count;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_loading <= 1; m_halted <= 0; m_step <= 0;
      m_pcclr <= 0; m_full <= 0;
      m_phase <= 0; m_addr <= 0; m_count <= 0;
    end else begin
      m_pcclr <= 0;
      if (m_loading) begin
        if (load_valid) begin
          if (load_last || m_addr == DEPTH - 1) begin
            if (!load_last) m_full <= 1;
            m_addr <= 0; m_pcclr <= 1; m_loading <= 0;
            m_phase <= 0; m_step <= 0;
            m_halted <= !(run_en && !halt_req);
          end else begin
            m_addr <= m_addr + 1;
          end
        end
      end else if (m_halted) begin
        if (reload_req) begin
          m_loading <= 1; m_halted <= 0;
          m_addr <= 0; m_full <= 0;
        end else if (step_req) begin
          m_halted <= 0; m_phase <= 0; m_step <= 1;
        end else if (run_en && !halt_req) begin
          m_halted <= 0; m_phase <= 0;
        end
      end else if (m_phase < 2) begin
        m_phase <= m_phase + 1;
      end else begin
        m_count <= (m_count + 1) % 65536;
        if (halt_req || !run_en || m_step) begin
          m_halted <= 1; m_step <= 0;
        end else begin
          m_phase <= 0;
        end
      end
    end
  end

  int wq[$];
  int pcclr_seen = 0;

  always @(negedge clk) begin
    int es;
    es = m_loading ? 0 : (m_halted ? 3 : m_phase + 1);
    check("stage", 32'(stage), 32'(es));
    check("stage_valid", 32'(stage_valid), 32'(!m_halted));
    check("load_ready", 32'(load_ready), 32'(m_loading));
    check("we", 32'(pmem_load_we),
          32'(m_loading && load_valid));
    check("addr", 32'(pmem_load_addr), 32'(m_addr));
    check("pc_clr", 32'(pc_clr), 32'(m_pcclr));
    check("load_full", 32'(load_full), 32'(m_full));
    check("instr_count", 32'(instr_count), 32'(m_count));
    if (pmem_load_we) begin
      check("wdata", 32'(pmem_load_data), 32'(load_data));
      wq.push_back(int'(pmem_load_addr));
    end
    if (pc_clr) pcclr_seen++;
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_stage(logic [1:0] s, logic v);
    int k;
    k = 0;
    while (!(stage == s && stage_valid == v) && k < 20) begin
      tick();
      k++;
    end
    check("wait_stage_timeout", 32'(k < 20), 32'(1));
  endtask

  task automatic offer(logic [IW-1:0] d, logic last);
    load_valid = 1; load_data = d; load_last = last;
    tick();
    load_valid = 0; load_last = 0;
  endtask

  logic [15:0] c0;

  initial begin
    tick(2);
    #2 rst = 0;
    tick();
    check("rst_stage", 32'(stage), 32'(0));
    check("rst_valid", 32'(stage_valid), 32'(1));
    check("rst_ready", 32'(load_ready), 32'(1));
    check("rst_count", 32'(instr_count), 32'(0));

    // three-word image, then free-run
    run_en = 1;
    wq.delete();
    offer(12'h123, 0);
    offer(12'h456, 0);
    offer(12'h789, 1);
    check("t1_nwrites", 32'(wq.size()), 32'(3));
    check("t1_a0", 32'(wq[0]), 32'(0));
    check("t1_a2", 32'(wq[2]), 32'(2));
    check("t1_pcclr", 32'(pc_clr), 32'(1));
    check("t1_fetch", 32'(stage), 32'(1));
    tick();
    check("t1_decode", 32'(stage), 32'(2));
    tick();
    check("t1_exec", 32'(stage), 32'(3));
    tick(4);
    check("t1_count2", 32'(instr_count), 32'(2));
    check("t1_pcclr_once", 32'(pcclr_seen), 32'(1));

    // halt requested during DECODE
    wait_stage(2'b10, 1'b1);
    halt_req = 1;
    c0 = instr_count;
    tick();
    check("h_exec", 32'(stage), 32'(3));
    check("h_exec_valid", 32'(stage_valid), 32'(1));
    tick();
    check("h_halted", 32'(stage_valid), 32'(0));
    check("h_count", 32'(instr_count), 32'(c0 + 16'd1));
    tick(3);
    check("h_frozen", 32'(instr_count), 32'(c0 + 16'd1));
    halt_req = 0;
    tick();
    check("h_resume", 32'(stage), 32'(1));

    // single step from HALT
    run_en = 0;
    wait_stage(2'b11, 1'b0);
    c0 = instr_count;
    step_req = 1;
    tick();
    step_req = 0;
    check("s_fetch", 32'(stage), 32'(1));
    tick();
    check("s_decode", 32'(stage), 32'(2));
    step_req = 1;
    tick();
    step_req = 0;
    check("s_exec", 32'(stage), 32'(3));
    tick();
    check("s_halt", 32'(stage_valid), 32'(0));
    check("s_count", 32'(instr_count), 32'(c0 + 16'd1));
    tick(4);
    check("s_stay", 32'(stage_valid), 32'(0));

    // reload, then gapped load of two words
    reload_req = 1;
    tick();
    reload_req = 0;
    check("r_stage", 32'(stage), 32'(0));
    wq.delete();
    offer(12'h0a1, 0);
    tick();
    offer(12'h0b2, 1);
    tick();
    check("g_nwrites", 32'(wq.size()), 32'(2));
    check("g_a1", 32'(wq[1]), 32'(1));
    check("g_addr0", 32'(pmem_load_addr), 32'(0));
    check("g_halt", 32'(stage_valid), 32'(0));

    // overfill: 5 words into a 4-word memory
    reload_req = 1;
    tick();
    reload_req = 0;
    wq.delete();
    for (int i = 0; i < 5; i++) offer(IW'(i + 16), 0);
    check("f_nwrites", 32'(wq.size()), 32'(4));
    check("f_a3", 32'(wq[3]), 32'(3));
    check("f_full", 32'(load_full), 32'(1));
    check("f_ready", 32'(load_ready), 32'(0));

    // reload clears load_full
    reload_req = 1;
    tick();
    reload_req = 0;
    check("rl_stage", 32'(stage), 32'(0));
    check("rl_ready", 32'(load_ready), 32'(1));
    check("rl_addr", 32'(pmem_load_addr), 32'(0));
    check("rl_full", 32'(load_full), 32'(0));

    // async reset in the middle of FETCH
    run_en = 1;
    offer(12'h321, 1);
    check("ar_fetch", 32'(stage), 32'(1));
    #2 rst = 1;
    #1;
    check("ar_stage", 32'(stage), 32'(0));
    check("ar_count", 32'(instr_count), 32'(0));
    check("ar_ready", 32'(load_ready), 32'(1));
    tick(2);
    rst = 0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
